// File: rtl/mdu_iter.sv
// Iterative RISC-V M-extension unit: shift-add multiply and restoring
// divide, one bit per cycle, with early exit for divide-by-zero/overflow.
module mdu_iter #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [2:0]       md_op,
    input  logic [WIDTH-1:0] operand1,
    input  logic [WIDTH-1:0] operand2,
    input  logic             flush,
    output logic             busy,
    output logic             valid,
    output logic [WIDTH-1:0] result
);

    localparam int CW = $clog2(WIDTH + 1);
    localparam logic [WIDTH-1:0] MIN_NEG = {1'b1, {(WIDTH-1){1'b0}}};

    typedef enum logic [1:0] {
        IDLE,
        CALC,
        DONE
    } state_t;

    state_t             state;
    logic [CW-1:0]      cnt;
    logic [2:0]         op_q;
    logic [WIDTH-1:0]   mag1_q;
    logic [WIDTH-1:0]   mag2_q;
    logic               neg_q;
    logic               rneg_q;
    logic [2*WIDTH-1:0] p;

    logic               s1_in;
    logic               s2_in;
    logic               n1_in;
    logic               n2_in;
    logic [WIDTH-1:0]   mag1_in;
    logic [WIDTH-1:0]   mag2_in;
    logic               div_zero;
    logic               div_ovf;
    logic [WIDTH-1:0]   early_res;

    assign s1_in = (md_op == 3'b001) | (md_op == 3'b010)
                 | (md_op == 3'b100) | (md_op == 3'b110);
    assign s2_in = (md_op == 3'b001) | (md_op == 3'b100)
                 | (md_op == 3'b110);
    assign n1_in = s1_in & operand1[WIDTH-1];
    assign n2_in = s2_in & operand2[WIDTH-1];
    assign mag1_in = n1_in ? -operand1 : operand1;
    assign mag2_in = n2_in ? -operand2 : operand2;

    assign div_zero = md_op[2] & (operand2 == '0);
    assign div_ovf  = md_op[2] & ~md_op[0]
                    & (operand1 == MIN_NEG) & (operand2 == '1);

    // Zero divisor takes precedence; overflow only applies to signed ops.
    always_comb begin
        early_res = '0;
        if (div_zero)
            early_res = md_op[1] ? operand1 : '1;
        else
            early_res = md_op[1] ? '0 : operand1;
    end

    logic [WIDTH:0]     mul_sum;
    logic [WIDTH:0]     rem_try;
    logic               rem_ge;
    logic [WIDTH-1:0]   rem_diff;
    logic [WIDTH-1:0]   rem_new;
    logic [2*WIDTH-1:0] p_nxt;

    assign mul_sum  = {1'b0, p[2*WIDTH-1:WIDTH]}
                    + (p[0] ? {1'b0, mag1_q} : '0);
    assign rem_try  = {p[2*WIDTH-1:WIDTH], p[WIDTH-1]};
    assign rem_ge   = rem_try >= {1'b0, mag2_q};
    assign rem_diff = rem_try[WIDTH-1:0] - mag2_q;
    assign rem_new  = rem_ge ? rem_diff : rem_try[WIDTH-1:0];

    // Multiply shifts the product right; divide shifts quotient bits in at the bottom.
    assign p_nxt = op_q[2] ? {rem_new, p[WIDTH-2:0], rem_ge}
                           : {mul_sum, p[WIDTH-1:1]};

    logic [2*WIDTH-1:0] prod_fix;
    logic [WIDTH-1:0]   quo_fix;
    logic [WIDTH-1:0]   rem_fix;
    logic [WIDTH-1:0]   fin_res;

    assign prod_fix = neg_q ? -p_nxt : p_nxt;
    assign quo_fix  = neg_q ? -p_nxt[WIDTH-1:0] : p_nxt[WIDTH-1:0];
    assign rem_fix  = rneg_q ? -p_nxt[2*WIDTH-1:WIDTH]
                             : p_nxt[2*WIDTH-1:WIDTH];

    always_comb begin
        fin_res = '0;
        if (op_q[2])
            fin_res = op_q[1] ? rem_fix : quo_fix;
        else if (op_q[1:0] == 2'b00)
            fin_res = prod_fix[WIDTH-1:0];
        else
            fin_res = prod_fix[2*WIDTH-1:WIDTH];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= IDLE;
            cnt    <= '0;
            op_q   <= '0;
            mag1_q <= '0;
            mag2_q <= '0;
            neg_q  <= 1'b0;
            rneg_q <= 1'b0;
            p      <= '0;
            result <= '0;
        end else if (flush) begin
            state <= IDLE;
            cnt   <= '0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (start) begin
                        op_q   <= md_op;
                        mag1_q <= mag1_in;
                        mag2_q <= mag2_in;
                        neg_q  <= n1_in ^ n2_in;
                        rneg_q <= n1_in;
                        p      <= {{WIDTH{1'b0}},
                                   md_op[2] ? mag1_in : mag2_in};
                        if (div_zero || div_ovf) begin
                            result <= early_res;
                            state  <= DONE;
                        end else begin
                            cnt   <= CW'(WIDTH);
                            state <= CALC;
                        end
                    end
                end
                CALC: begin
                    p   <= p_nxt;
                    cnt <= cnt - 1'b1;
                    if (cnt == CW'(1)) begin
                        result <= fin_res;
                        state  <= DONE;
                    end
                end
                DONE: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    assign busy  = (state != IDLE);
    assign valid = (state == DONE);

endmodule

// File: doc/mdu_iter.md
MDU_ITER -- requirements
Module: mdu_iter

Interface
REQ-001 SHALL have parameter WIDTH, default 32, datapath width in bits; legal range 4 to 64, even values only.
REQ-002 SHALL have port clk  input  1  the single clock; all state updates on its rising edge.
REQ-003 SHALL have port rst_n  input  1  reset, asynchronous assert, active-low.
REQ-004 SHALL have port start  input  1  request strobe; sampled only in IDLE.
REQ-005 SHALL have port md_op  input  3  operation code: 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU.
REQ-006 SHALL have port operand1  input  WIDTH  multiplicand / dividend.
REQ-007 SHALL have port operand2  input  WIDTH  multiplier / divisor.
REQ-008 SHALL have port flush  input  1  synchronous abort of any in-flight operation.
REQ-009 SHALL have port busy  output  1  high whenever state is not IDLE.
REQ-010 SHALL have port valid  output  1  one-cycle pulse marking result as new.
REQ-011 SHALL have port result  output  WIDTH  registered result.

Function
REQ-012 SHALL implement FSM states IDLE, CALC, DONE; valid = (state==DONE); busy = (state!=IDLE).
REQ-013 SHALL, on an edge in IDLE with start=1 and flush=0, capture md_op, operand1 and operand2 into internal registers; later input changes SHALL NOT affect the operation.
REQ-014 SHALL ignore start while busy=1: no capture, no state change.
REQ-015 SHALL treat MULH/MULHSU/DIV/REM operand1 as signed, and MULH/DIV/REM operand2 as signed; all other operands unsigned.
REQ-016 SHALL compute the full 2*WIDTH-bit product by iterative shift-add on magnitudes, one bit per CALC cycle, then apply sign correction; MUL returns low WIDTH bits, MULH/MULHSU/MULHU return high WIDTH bits.
REQ-017 SHALL compute division by restoring radix-2 iteration on magnitudes, one quotient bit per CALC cycle; quotient negated when operand signs differ (signed ops); remainder takes sign of dividend.
REQ-018 SHALL take IDLE->CALC on accept for normal operations, stay in CALC exactly WIDTH cycles using a down-counter, then CALC->DONE; valid therefore rises WIDTH+1 edges after the accepting edge (33 for WIDTH=32).
REQ-019 SHALL detect divisor zero (DIV/DIVU/REM/REMU) at accept and go IDLE->DONE directly (valid 1 edge after accept): quotient = all ones, remainder = operand1.
REQ-020 SHALL detect signed overflow (DIV/REM, operand1 = 1 followed by WIDTH-1 zeros, operand2 = all ones) at accept and go IDLE->DONE directly: quotient = operand1, remainder = 0.
REQ-021 SHALL load result on the edge entering DONE and hold it unchanged until the next edge entering DONE.
REQ-022 SHALL leave DONE for IDLE after exactly one cycle; a start asserted during DONE SHALL be ignored; start SHALL be accepted in the first IDLE cycle after DONE.
REQ-023 SHALL, when flush=1 at an edge, force state to IDLE from any state, suppress valid and leave result unchanged; flush has priority over start in IDLE.
REQ-024 SHALL produce all arithmetic modulo 2^WIDTH; sign correction uses two's complement of the 2*WIDTH product or WIDTH-bit quotient/remainder.

Reset
REQ-025 SHALL, while rst_n=0, hold state=IDLE, busy=0, valid=0, result=0, counter=0 and internal operand registers=0, regardless of clk.
REQ-026 SHALL, if reset asserts mid-operation, discard the operation; after release the first start is accepted normally.

Verification
REQ-027 SHALL cover MUL 7 x 0xFFFFFFFD -> result 0xFFFFFFEB, valid one pulse exactly 33 edges after accept, busy high for 33 cycles.
REQ-028 SHALL cover MULH 0x80000000 x 0x80000000 -> 0x40000000; MULHU 0xFFFFFFFF x 0xFFFFFFFF -> 0xFFFFFFFE; MULHSU 0xFFFFFFFF x 0xFFFFFFFF -> 0xFFFFFFFF.
REQ-029 SHALL cover DIV 0xFFFFFFF9 / 2 -> 0xFFFFFFFD; REM same -> 0xFFFFFFFF; DIVU 100 / 7 -> 14; REMU 100 / 7 -> 2.
REQ-030 SHALL cover DIVU 5 / 0 -> 0xFFFFFFFF and REM 5 / 0 -> 5, DIV 0x80000000 / 0xFFFFFFFF -> 0x80000000 and REM -> 0, each with valid 1 edge after accept.
REQ-031 SHALL cover start pulsed while busy (operand change ignored, original result returned) and flush at CALC cycle 10 -> busy=0 next cycle, no valid, result unchanged, next start accepted.
REQ-032 SHALL cover rst_n low mid-CALC -> busy, valid, result 0 immediately (asynchronous); subsequent MUL 3 x 4 -> 12.
